logic_op_arbiter: RTL



---
 rtl/logic_op_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one AND/OR evaluation unit among NREQ requesters.
// Optional LOGIC_ARB_OPCOUNT_EN adds a saturating response counter (op_count).
module logic_op_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [IDW-1:0]    rsp_id
`ifdef LOGIC_ARB_OPCOUNT_EN
    ,
    output logic [15:0]       op_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        RESP
    } state_t;

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  id_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            op_q;
    logic            found;
    logic [IDW:0]    sum;
    logic [IDW-1:0]  idx;
    logic [NREQ-1:0] grant_vec;

    // Search starts at rr_ptr and wraps, so the last winner goes to the back.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            idx = (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : IDW'(sum);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign grant_vec = found ? ({{(NREQ-1){1'b0}}, 1'b1} << winner) : '0;
    assign req_ready = (rst_n && state == IDLE) ? grant_vec : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        a_q    <= req_a[winner*W +: W];
                        b_q    <= req_b[winner*W +: W];
                        op_q   <= req_op[winner];
                        id_q   <= winner;
                        rr_ptr <= (winner == LAST) ? '0 : winner + 1'b1;
                        state  <= EVAL;
                    end
                end
                EVAL: begin
                    rsp_data  <= op_q ? (a_q | b_q) : (a_q & b_q);
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOGIC_ARB_OPCOUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (rsp_valid && rsp_ready && op_count != 16'hFFFF) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule
